p2tdm: RTL

Serializer for the audio transmit path. It takes 256-bit parallel sample frames (8 channels x 32 bits, CH1 MSB at bit 255, CH8 LSB at bit 0) and drives a TDM serial link: a generated serial clock `sclk`, a frame sync `fs` and serial data `tdmout`. Data changes on `sclk` falling edges and is stable for sampling on `sclk` rising edges. Frames are sent back to back. A one-deep holding buffer with a valid/ready handshake decouples the producer from frame timing.

---
 rtl/p2tdm.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/p2tdm.sv
// TDM serializer: 256-bit parallel frames (8 x 32-bit channels) out on sclk/fs/tdmout,
// with a one-deep valid/ready holding buffer in front of the frame shifter.
module p2tdm #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [255:0] pdata,
    input  logic         pvalid,
    output logic         pready,
    output logic         sclk,
    output logic         fs,
    output logic         tdmout,
    output logic         frame_start,
    output logic         underrun
);

    localparam int unsigned           DIV_W    = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [7:0]         bit_q, bit_d;
    logic [255:0]       shifter_q, shifter_d;
    logic [255:0]       buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic               pready_q, pready_d;
    logic               sclk_q, sclk_d;
    logic               fs_q, fs_d;
    logic               tdmout_q, tdmout_d;
    logic               frame_start_q, frame_start_d;
    logic               underrun_q, underrun_d;

    logic               xfer;
    logic               boundary;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        shifter_d     = shifter_q;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        sclk_d        = sclk_q;
        fs_d          = fs_q;
        tdmout_d      = tdmout_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        boundary      = 1'b0;
        xfer          = pvalid && pready_q;

        if (!enable) begin
            state_d  = IDLE;
            div_d    = '0;
            bit_d    = 8'd255;
            sclk_d   = 1'b0;
            fs_d     = 1'b0;
            tdmout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = LEAD;
                    div_d    = '0;
                    sclk_d   = 1'b0;
                    fs_d     = 1'b1;
                    tdmout_d = 1'b0;
                end
                LEAD, RUN: begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        sclk_d = 1'b0;
                        if (state_q == LEAD || bit_q == 8'd0) begin
                            boundary = 1'b1;
                            state_d  = RUN;
                            bit_d    = 8'd255;
                        end else begin
                            bit_d    = bit_q - 8'd1;
                            tdmout_d = shifter_q[bit_d];
                            // The LSB slot of CH8 doubles as the frame sync of the next frame.
                            fs_d     = (bit_d == 8'd0);
                        end
                    end else begin
                        div_d  = div_q + DIV_ONE;
                        sclk_d = (div_d >= DIV_HALF);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (boundary) begin
            fs_d = 1'b0;
            if (buf_full_q) begin
                shifter_d     = buf_q;
                buf_full_d    = 1'b0;
                frame_start_d = 1'b1;
                tdmout_d      = buf_q[255];
            end else begin
                shifter_d  = '0;
                underrun_d = 1'b1;
                tdmout_d   = 1'b0;
            end
        end

        // pready high implies the buffer is empty, so a transfer never collides with a load.
        if (xfer) begin
            buf_d      = pdata;
            buf_full_d = 1'b1;
        end
        pready_d = !(buf_full_q || xfer);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; all flops, buffer included, are reset.
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bit_q         <= 8'd255;
            shifter_q     <= '0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            pready_q      <= 1'b1;
            sclk_q        <= 1'b0;
            fs_q          <= 1'b0;
            tdmout_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            shifter_q     <= shifter_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            pready_q      <= pready_d;
            sclk_q        <= sclk_d;
            fs_q          <= fs_d;
            tdmout_q      <= tdmout_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pready      = pready_q;
    assign sclk        = sclk_q;
    assign fs          = fs_q;
    assign tdmout      = tdmout_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule
